pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (pc_reg → if_id → id → id_ex → ex).
- Arbitrates redirect, load-use stall, external bus hold and debug halt, and drives hold/flush to pipeline registers plus the PC redirect.
- Owns the halt/drain and hold sequencing state machine.
- All hazard outputs are combinational from the registered state and the current inputs.

Parameters:
- DRAIN_CYC, 2, cycles of id_ex flush after halt acceptance before reporting halted (in-flight stages past id).
- HOLD_TIMEOUT, 255, consecutive hold cycles after which hold_timeout_o sets; 0 disables timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  ex requests redirect (branch taken / JAL)
- jump_addr_i  in  32  redirect target
- rs1_addr_i  in  5  id source 1 (0 = unused)
- rs2_addr_i  in  5  id source 2 (0 = unused)
- ex_rd_addr_i  in  5  destination of instruction in ex
- ex_reg_wen_i  in  1  ex instruction writes rd
- ex_is_load_i  in  1  ex instruction is a load
- hold_req_i  in  1  bus/fetch busy, level
- halt_req_i  in  1  debug halt request, level
- resume_i  in  1  debug resume, pulse
- jump_en_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- pc_hold_o  out  1  freeze pc_reg
- if_id_hold_o  out  1  freeze if_id
- if_id_flush_o  out  1  load NOP into if_id
- id_ex_flush_o  out  1  load NOP (reg_wen=0, rd=0) into id_ex
- halted_o  out  1  core halted
- hold_timeout_o  out  1  sticky, hold exceeded HOLD_TIMEOUT
- state_o  out  2  FSM state

Behaviour:
- Reset (async, rst_n=0): state=RUN, counters=0, hold_timeout_o=0. Combinational outputs evaluate from RUN with the current inputs; with all inputs idle, every output is 0.
- States: RUN=0, HOLD=1, DRAIN=2, HALT=3.
- Redirect, any state: jump_en_i=1 → jump_en_o=1, jump_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1 in the same cycle. Otherwise jump_addr_o=0.
  - pc_reg gives jump_en_o priority over pc_hold_o.
  - Redirect never changes the state transition.
- RUN, evaluated in priority order:
  - halt_req_i → next DRAIN, drain counter=0.
  - else hold_req_i → next HOLD, hold counter=0.
  - else load-use: ex_is_load_i & ex_reg_wen_i & ex_rd_addr_i≠0 & (ex_rd_addr_i==rs1_addr_i | ex_rd_addr_i==rs2_addr_i) → pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 for that cycle only; stay RUN.
  - A load-use stall coinciding with jump_en_i is suppressed: redirect wins and if_id_hold_o=0.
- HOLD:
  - Outputs: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1.
  - Hold counter increments, saturating at 2^16-1.
  - Counter reaching HOLD_TIMEOUT (non-zero) sets hold_timeout_o; it clears only on reset.
  - hold_req_i=0 → RUN next cycle.
  - halt_req_i=1 → DRAIN (halt has priority over the hold release).
- DRAIN:
  - Outputs: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1.
  - Counter increments each cycle; at DRAIN_CYC-1 → HALT.
  - halt_req_i dropping during DRAIN does not abort; the drain completes.
- HALT:
  - Outputs: halted_o=1, pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1.
  - resume_i=1 → RUN next cycle, even if halt_req_i is still high; re-entry to DRAIN occurs one cycle later.
  - hold_req_i is ignored in HALT.
- rst_n asserted mid-DRAIN or mid-HOLD returns to RUN immediately; no partial state persists.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: adds output ports stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o counts cycles with pc_hold_o=1.
  - flush_cnt_o counts cycles with if_id_flush_o=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Shared defines header: state encodings (PC_RUN/PC_HOLD/PC_DRAIN/PC_HALT), ZERO_REG 5'd0, NOP encoding 32'h00000013 used by flushed registers.
- One sub-module: pipe_ctrl_perf, two 32-bit enable counters, instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset with all inputs 0 → all outputs 0, state_o=0; async release mid-cycle is glitch-free.
- ex load to x5 (ex_is_load_i=1, ex_reg_wen_i=1, rd=5), id rs2_addr_i=5 → exactly 1 cycle of pc_hold_o/if_id_hold_o/id_ex_flush_o. Same with rd=0 → no stall.
- jump_en_i=1, jump_addr_i=32'h0000_0100 simultaneous with load-use match → jump_en_o=1, addr 0x100, both flushes=1, if_id_hold_o=0.
- hold_req_i high 300 cycles, HOLD_TIMEOUT=255 → state_o=1 throughout, hold_timeout_o rises on the 255th hold cycle and stays 1 after release; RUN one cycle after hold_req_i falls.
- halt_req_i pulse 1 cycle in RUN → DRAIN 2 cycles, then halted_o=1; resume_i pulse → RUN next cycle; jump_en_i during DRAIN still gives jump_en_o=1.
- With PIPE_CTRL_PERF_EN: 3 load-use stalls + 4 HOLD cycles → stall_cnt_o=7; 2 jumps → flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// the hard-wired zero register index, the NOP instruction that flushed
// pipeline registers load, and the load-use hazard detector.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_RUN   = 2'd0,
      PC_HOLD  = 2'd1,
      PC_DRAIN = 2'd2,
      PC_HALT  = 2'd3
   } pc_state_e;

   localparam logic [4:0]  ZERO_REG     = 5'd0;
   localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
   localparam logic [15:0] HOLD_CNT_MAX = 16'hFFFF;

   // A load in ex whose destination is read by the instruction in id.
   // Writes to x0 never create a dependency.
   function automatic logic load_use_hit(
      input logic       is_load,
      input logic       reg_wen,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2
   );
      return is_load & reg_wen & (rd != ZERO_REG) & ((rd == rs1) | (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for the pipeline controller: one counts stalled
// cycles, the other counts front-end flushes. Both wrap at 2^32.
// Instantiated by pipe_ctrl only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_en,
   input  logic        flush_en,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   // Count enabled cycles; the counters simply wrap on overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (stall_en) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush_en) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core. Arbitrates ex redirect,
// load-use stall, external bus hold and debug halt, and drives hold/flush
// to the pipeline registers plus the PC redirect. Hazard outputs are
// combinational from the registered FSM state and the current inputs.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYC    = 2,
   parameter int unsigned HOLD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_reg_wen_i,
   input  logic        ex_is_load_i,
   input  logic        hold_req_i,
   input  logic        halt_req_i,
   input  logic        resume_i,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o,
   output logic        pc_hold_o,
   output logic        if_id_hold_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        halted_o,
   output logic        hold_timeout_o,
   output logic [1:0]  state_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   // A drain of zero cycles is treated as one: DRAIN always lasts >= 1 cycle.
   localparam logic [15:0] DRAIN_LAST = (DRAIN_CYC > 32'd1) ? 16'(DRAIN_CYC - 32'd1) : 16'd0;
   localparam logic        TIMEOUT_EN = (HOLD_TIMEOUT != 32'd0);

   pc_state_e   state_r;
   logic [15:0] hold_cnt_r;
   logic [15:0] drain_cnt_r;
   logic        timeout_r;

   logic        load_use_s;
   logic        stall_s;
   logic [15:0] hold_inc_s;
   logic        timeout_hit_s;

   // Load-use stall only in RUN when nothing of higher priority is pending;
   // a coincident redirect flushes the dependent instruction anyway.
   always_comb begin
      load_use_s = 1'b0;
      if ((state_r == PC_RUN) && !halt_req_i && !hold_req_i && !jump_en_i) begin
         load_use_s = load_use_hit(ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i,
                                   rs1_addr_i, rs2_addr_i);
      end else begin
         load_use_s = 1'b0;
      end
   end

   // Saturating hold-cycle increment and the timeout match on it.
   always_comb begin
      hold_inc_s    = hold_cnt_r;
      timeout_hit_s = 1'b0;
      if (hold_cnt_r != HOLD_CNT_MAX) begin
         hold_inc_s = hold_cnt_r + 16'd1;
      end else begin
         hold_inc_s = hold_cnt_r;
      end
      if (TIMEOUT_EN && ({16'd0, hold_inc_s} == HOLD_TIMEOUT)) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Hazard outputs: any non-RUN state freezes the front end and bubbles id_ex.
   always_comb begin
      stall_s       = (state_r != PC_RUN) | load_use_s;
      jump_en_o     = jump_en_i;
      jump_addr_o   = 32'd0;
      if (jump_en_i) begin
         jump_addr_o = jump_addr_i;
      end else begin
         jump_addr_o = 32'd0;
      end
      pc_hold_o     = stall_s;
      if_id_hold_o  = stall_s;
      if_id_flush_o = jump_en_i;
      id_ex_flush_o = jump_en_i | stall_s;
      halted_o      = (state_r == PC_HALT);
   end

   // Halt/drain/hold sequencing FSM with its counters and sticky timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= PC_RUN;
         hold_cnt_r  <= 16'd0;
         drain_cnt_r <= 16'd0;
         timeout_r   <= 1'b0;
      end else begin
         case (state_r)
            PC_RUN: begin
               if (halt_req_i) begin
                  state_r     <= PC_DRAIN;
                  drain_cnt_r <= 16'd0;
               end else if (hold_req_i) begin
                  state_r    <= PC_HOLD;
                  hold_cnt_r <= 16'd0;
               end
            end
            PC_HOLD: begin
               hold_cnt_r <= hold_inc_s;
               if (timeout_hit_s) begin
                  timeout_r <= 1'b1;
               end
               if (halt_req_i) begin
                  state_r     <= PC_DRAIN;
                  drain_cnt_r <= 16'd0;
               end else if (!hold_req_i) begin
                  state_r <= PC_RUN;
               end
            end
            PC_DRAIN: begin
               // Dropping halt_req_i here does not abort the drain.
               if (drain_cnt_r >= DRAIN_LAST) begin
                  state_r <= PC_HALT;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 16'd1;
               end
            end
            PC_HALT: begin
               // Only resume leaves HALT; hold requests are ignored here.
               if (resume_i) begin
                  state_r <= PC_RUN;
               end
            end
            default: begin
               state_r <= PC_RUN;
            end
         endcase
      end
   end

   assign state_o        = state_r;
   assign hold_timeout_o = timeout_r;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_en  (pc_hold_o),
      .flush_en  (if_id_flush_o),
      .stall_cnt (stall_cnt_o),
      .flush_cnt (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process computes each
// cycle's expected outputs from a mode-level reference model and queues
// them; an independent monitor pops and compares every cycle.
module tb_pipe_ctrl;

   localparam int DRAIN_CYC    = 2;
   localparam int HOLD_TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic [4:0]  rs1_addr_i, rs2_addr_i, ex_rd_addr_i;
   logic        ex_reg_wen_i, ex_is_load_i, hold_req_i, halt_req_i, resume_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o;
   logic        halted_o, hold_timeout_o;
   logic [1:0]  state_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

   pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_wen_i(ex_reg_wen_i),
      .ex_is_load_i(ex_is_load_i), .hold_req_i(hold_req_i),
      .halt_req_i(halt_req_i), .resume_i(resume_i),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
      .pc_hold_o(pc_hold_o), .if_id_hold_o(if_id_hold_o),
      .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
      .halted_o(halted_o), .hold_timeout_o(hold_timeout_o),
      .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        jump_en;
      logic [31:0] jump_addr;
      logic        pc_hold;
      logic        if_id_hold;
      logic        if_id_flush;
      logic        id_ex_flush;
      logic        halted;
      logic        tmo;
      logic [1:0]  state;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference model: mode 0 run, 1 hold, 2 drain, 3 halted.
   int          m_mode       = 0;
   int          m_drain_left = 0;
   int          m_hold_run   = 0;
   bit          m_tmo        = 1'b0;
   int unsigned m_stall      = 0;
   int unsigned m_flush      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One cycle of stimulus: apply inputs at negedge, queue the expectation,
   // then advance the model to what the next rising edge produces.
   task automatic cyc(input bit rst, input bit jmp, input logic [31:0] addr,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input bit wen, input bit ld, input bit hld, input bit hlt, input bit res);
      exp_t e;
      bit busy, lu;
      @(negedge clk);
      rst_n = rst; jump_en_i = jmp; jump_addr_i = addr;
      rs1_addr_i = r1; rs2_addr_i = r2; ex_rd_addr_i = rd;
      ex_reg_wen_i = wen; ex_is_load_i = ld;
      hold_req_i = hld; halt_req_i = hlt; resume_i = res;
      if (!rst) begin
         m_mode = 0; m_drain_left = 0; m_hold_run = 0; m_tmo = 1'b0;
         m_stall = 0; m_flush = 0;
      end
      busy = (m_mode != 0);
      lu   = (m_mode == 0) && !hlt && !hld && !jmp && ld && wen && (rd != 5'd0)
             && (rd == r1 || rd == r2);
      e.jump_en     = jmp;
      e.jump_addr   = jmp ? addr : 32'd0;
      e.pc_hold     = busy || lu;
      e.if_id_hold  = busy || lu;
      e.if_id_flush = jmp;
      e.id_ex_flush = jmp || busy || lu;
      e.halted      = (m_mode == 3);
      e.tmo         = m_tmo;
      e.state       = 2'(m_mode);
      e.stall       = m_stall;
      e.flush       = m_flush;
      sb_q.push_back(e);
      if (rst) begin
         if (e.pc_hold) m_stall++;
         if (jmp) m_flush++;
         case (m_mode)
            0: if (hlt) begin m_mode = 2; m_drain_left = DRAIN_CYC; end
               else if (hld) begin m_mode = 1; m_hold_run = 0; end
            1: begin
               m_hold_run++;
               if (HOLD_TIMEOUT != 0 && m_hold_run >= HOLD_TIMEOUT) m_tmo = 1'b1;
               if (hlt) begin m_mode = 2; m_drain_left = DRAIN_CYC; end
               else if (!hld) m_mode = 0;
            end
            2: begin
               m_drain_left--;
               if (m_drain_left <= 0) m_mode = 3;
            end
            3: if (res) m_mode = 0;
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compares every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("jump_en",     32'(jump_en_o),      32'(e.jump_en));
            chk("jump_addr",   jump_addr_o,         e.jump_addr);
            chk("pc_hold",     32'(pc_hold_o),      32'(e.pc_hold));
            chk("if_id_hold",  32'(if_id_hold_o),   32'(e.if_id_hold));
            chk("if_id_flush", 32'(if_id_flush_o),  32'(e.if_id_flush));
            chk("id_ex_flush", 32'(id_ex_flush_o),  32'(e.id_ex_flush));
            chk("halted",      32'(halted_o),       32'(e.halted));
            chk("hold_tmo",    32'(hold_timeout_o), 32'(e.tmo));
            chk("state",       32'(state_o),        32'(e.state));
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cnt",   stall_cnt_o,         e.stall);
            chk("flush_cnt",   flush_cnt_o,         e.flush);
`endif
         end
      end
   end

   // Stimulus: directed scenarios first, then a randomized soak.
   initial begin
      rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'd0;
      rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
      ex_reg_wen_i = 1'b0; ex_is_load_i = 1'b0;
      hold_req_i = 1'b0; halt_req_i = 1'b0; resume_i = 1'b0;

      repeat (3) cyc(0, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      idle(2);
      // load to x5 used by rs2: one stall cycle
      cyc(1, 0, 32'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0);
      idle(1);
      // load to x0: no stall
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
      // redirect coinciding with load-use
      cyc(1, 1, 32'h0000_0100, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0);
      idle(1);
      // long hold crossing the timeout
      repeat (300) cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
      idle(3);
      // halt pulse, redirect during drain, resume
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      cyc(1, 1, 32'h0000_0200, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      idle(3);
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
      idle(2);
      // halt held through resume re-enters drain; hold ignored in halt
      repeat (4) cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      idle(3);
      repeat (3) cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
      idle(2);
      // reset mid-drain and mid-hold
      cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      cyc(0, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      idle(1);
      repeat (5) cyc(1, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
      cyc(0, 0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0), 32'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) == 0));
      end

      @(negedge clk);
      #5;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
